rtc_time_set: RTL
=================

// Module: rtc_time_set
// PURPOSE
//  Writer side of the RTC time registers: converts raw push-buttons into a time-set session
//  and commits a new HH:MM:SS to the RTC via a one-cycle load strobe.
//  Sits between board buttons and rtc; display_7seg reads set_* and blink while setting.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   cycles a synced button must be stable before its level is accepted
//  BLINK_CYCLES     25_000_000  half-period of blink output, in clk cycles
//  TIMEOUT_CYCLES   1_000_000_000  idle cycles in a set state before abort without load
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  btn_mode   in   1  raw button: enter set mode / advance field / commit
//  btn_inc    in   1  raw button: increment selected field
//  btn_dec    in   1  raw button: decrement selected field
//  cur_hour   in   5  live RTC hour, 0..23
//  cur_min    in   6  live RTC minute, 0..59
//  cur_sec    in   6  live RTC second, 0..59
//  set_active out  1  high while in SET_HOUR/SET_MIN/SET_SEC
//  set_field  out  2  0=none, 1=hour, 2=min, 3=sec
//  set_hour   out  5  shadow hour being edited / loaded
//  set_min    out  6  shadow minute
//  set_sec    out  6  shadow second
//  load       out  1  one-cycle strobe: RTC must load set_* on this edge
//  blink      out  1  toggles every BLINK_CYCLES while set_active; 0 otherwise
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; debouncers cleared to released; counters 0.
//  - Each button: 2-FF synchroniser -> debouncer -> rising-edge detect = 1-cycle press pulse.
//    Press latency from stable raw input: 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - FSM: IDLE --mode--> SET_HOUR (shadow <= cur_*, same edge)
//         SET_HOUR --mode--> SET_MIN --mode--> SET_SEC --mode--> COMMIT
//         COMMIT -> IDLE after exactly one cycle; load=1 only in COMMIT.
//  - set_* hold shadow values in all states; stay valid during and after COMMIT until next entry.
//  - inc/dec act only on selected field, one step per press pulse:
//    hour wraps 23->0 on inc, 0->23 on dec; min/sec wrap 59->0 and 0->59.
//  - Other fields are never touched by inc/dec; no carry between fields.
//  - inc and dec pulses in same cycle: both ignored.
//  - mode pulse together with inc/dec: mode wins, inc/dec dropped.
//  - inc/dec in IDLE: ignored, no state change.
//  - Timeout: counter clears on any press pulse and on state entry; reaching TIMEOUT_CYCLES in a set
//    state -> IDLE, load stays 0, shadow retained.
//  - blink: counter restarts at 0 on entry to SET_HOUR with blink=1; forced 0 in IDLE/COMMIT.
//  - Reset mid-session: immediate IDLE, no load.
//  - Held button yields a single press; no auto-repeat.
// STRUCTURE
//  - Package rtc_pkg: state enum (IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT),
//    field codes FIELD_NONE/HOUR/MIN/SEC, constants HOUR_MAX=23, MINSEC_MAX=59.
//  - One sub-module btn_debounce (sync + debounce + edge pulse; param DEBOUNCE_CYCLES),
//    instantiated three times.
//  - FSM, shadow registers, timeout and blink counters live in rtc_time_set.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=200)
//  1. cur=12:34:56; mode, inc x2, mode, dec, mode, mode -> single load pulse with set=14:33:56.
//  2. Hour wrap: enter with cur_hour=23, inc -> 0; dec -> 23.
//     Min wrap: cur_min=0, dec -> 59.
//  3. Bounce: btn_inc toggled every 2 cycles for 20 cycles, then held -> exactly one increment.
//  4. inc+dec pulses same cycle -> no change.
//     mode+inc same cycle in SET_HOUR -> SET_MIN, hour unchanged.
//  5. Enter SET_MIN, no presses for 200 cycles -> IDLE, load never asserted, set_active=0.
//  6. reset asserted in SET_SEC mid-blink -> outputs 0 same cycle (async).
//     After release, inc press -> no effect.

Source files
------------

// File: rtl/rtc_time_set_pkg.sv
// Shared types and constants for the RTC time-set block: FSM states, field codes
// and the wrap-around step used when editing a time field.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        COMMIT
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // One step up or down within 0..max_val, wrapping at both ends
    function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                             input logic [5:0] max_val,
                                             input logic       up);
        if (up)
            return (value >= max_val) ? 6'd0 : value + 6'd1;
        else
            return (value == 6'd0) ? max_val : value - 6'd1;
    endfunction

endpackage

// File: rtl/rtc_time_set_btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stability debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // The accepted level only follows the synced input after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            level_d <= level;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/rtc_time_set.sv
// Time-set session controller: turns debounced button presses into editing of a
// shadow HH:MM:SS and a one-cycle load strobe towards the RTC.
module rtc_time_set
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       set_active,
    output logic [1:0] set_field,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       blink
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);

    state_t           state_q;
    state_t           state_d;
    logic             mode_p;
    logic             inc_p;
    logic             dec_p;
    logic             any_press;
    logic             step_en;
    logic             timed_out;
    logic             next_in_set;
    logic [TMO_W-1:0] timeout_cnt;
    logic [BLK_W-1:0] blink_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .press(inc_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .press(dec_p));

    // Mode has priority; simultaneous inc and dec cancel each other out
    assign any_press = mode_p | inc_p | dec_p;
    assign step_en   = (inc_p ^ dec_p) & ~mode_p;
    assign timed_out = (timeout_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) & ~any_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        set_active = 1'b0;
        set_field  = FIELD_NONE;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_p) state_d = SET_HOUR;
            end
            SET_HOUR: begin
                set_active = 1'b1;
                set_field  = FIELD_HOUR;
                if (mode_p)         state_d = SET_MIN;
                else if (timed_out) state_d = IDLE;
            end
            SET_MIN: begin
                set_active = 1'b1;
                set_field  = FIELD_MIN;
                if (mode_p)         state_d = SET_SEC;
                else if (timed_out) state_d = IDLE;
            end
            SET_SEC: begin
                set_active = 1'b1;
                set_field  = FIELD_SEC;
                if (mode_p)         state_d = COMMIT;
                else if (timed_out) state_d = IDLE;
            end
            COMMIT: begin
                load    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign next_in_set = (state_d == SET_HOUR) || (state_d == SET_MIN) || (state_d == SET_SEC);

    // Shadow time: captured from the live RTC on session entry, then edited in place
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_hour <= '0;
            set_min  <= '0;
            set_sec  <= '0;
        end else if (state_q == IDLE && mode_p) begin
            set_hour <= cur_hour;
            set_min  <= cur_min;
            set_sec  <= cur_sec;
        end else if (step_en) begin
            case (state_q)
                SET_HOUR: set_hour <= 5'(step_wrap({1'b0, set_hour}, HOUR_MAX, inc_p));
                SET_MIN:  set_min  <= step_wrap(set_min, MINSEC_MAX, inc_p);
                SET_SEC:  set_sec  <= step_wrap(set_sec, MINSEC_MAX, inc_p);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout_cnt <= '0;
        else if (!next_in_set || state_d != state_q || any_press)
            timeout_cnt <= '0;
        else
            timeout_cnt <= timeout_cnt + 1'b1;
    end

    // Blink phase restarts high on every session entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (!next_in_set) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (state_q == IDLE) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule
